// File: rtl/mult_div_unit_pkg.sv
// Shared MD op codes and FSM state encodings for the multiply/divide unit
// (the same definitions the controller uses to generate md_op).
package mult_div_unit_pkg;
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;
  localparam logic [3:0] MD_MADD  = 4'd9;
  localparam logic [3:0] MD_MADDU = 4'd10;
  localparam logic [3:0] MD_MSUB  = 4'd11;
  localparam logic [3:0] MD_MSUBU = 4'd12;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} md_state_e;
endpackage

// File: rtl/mdu_latency_counter.sv
// Loadable down-counter; done_o flags the final busy cycle (count == 1).
module mdu_latency_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          done_o
);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)            cnt_d = load_val_i;
    else if (cnt_q != '0)  cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == CW'(1));
endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit with per-class latencies.
// Define MDU_MADD_EN to decode MADD/MADDU/MSUB/MSUBU accumulate ops.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic             flush,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] md_out
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_e        state_q, state_d;
  logic [WIDTH-1:0] hi_q, lo_q, hin_q, lon_q;
  logic             wen_q;
  logic             is_mul, is_div, is_madd, op_acc, cnt_done, commit, mt_ok;
  logic [CW-1:0]    lat;

  assign is_mul = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign is_div = (md_op == MD_DIV)  || (md_op == MD_DIVU);
`ifdef MDU_MADD_EN
  assign is_madd = (md_op == MD_MADD) || (md_op == MD_MADDU) ||
                   (md_op == MD_MSUB) || (md_op == MD_MSUBU);
`else
  assign is_madd = 1'b0;
`endif

  assign op_acc = (state_q == S_IDLE) && start && !flush && (is_mul || is_div || is_madd);
  assign mt_ok  = (state_q == S_IDLE) && !flush;
  assign lat    = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

  mdu_latency_counter #(.CW(CW)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (op_acc),
    .load_val_i (lat),
    .done_o     (cnt_done)
  );

  // Operands extended to 2*WIDTH so the products are full width.
  logic [2*WIDTH-1:0] a_s, b_s, a_u, b_u, prod_s, prod_u, acc;
  assign a_s    = {{WIDTH{A[WIDTH-1]}}, A};
  assign b_s    = {{WIDTH{B[WIDTH-1]}}, B};
  assign a_u    = {{WIDTH{1'b0}}, A};
  assign b_u    = {{WIDTH{1'b0}}, B};
  assign prod_s = a_s * b_s;
  assign prod_u = a_u * b_u;
  assign acc    = {hi_q, lo_q};

  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_we, div_ovf;
  assign div_ovf = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (&B);

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    res_we = 1'b1;
    case (md_op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        if (B == '0) res_we = 1'b0;
        else if (div_ovf) res_lo = A;
        else begin
          res_lo = WIDTH'($signed(A) / $signed(B));
          res_hi = WIDTH'($signed(A) % $signed(B));
        end
      end
      MD_DIVU: begin
        if (B == '0) res_we = 1'b0;
        else begin
          res_lo = A / B;
          res_hi = A % B;
        end
      end
      MD_MADD:  {res_hi, res_lo} = acc + prod_s;
      MD_MADDU: {res_hi, res_lo} = acc + prod_u;
      MD_MSUB:  {res_hi, res_lo} = acc - prod_s;
      MD_MSUBU: {res_hi, res_lo} = acc - prod_u;
      default:  res_we = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (op_acc)   state_d = S_BUSY;
      S_BUSY:  if (cnt_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Divide-by-zero leaves wen_q clear so the commit is skipped.
  assign commit = (state_q == S_BUSY) && cnt_done && wen_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      hin_q   <= '0;
      lon_q   <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (op_acc) begin
        hin_q <= res_hi;
        lon_q <= res_lo;
        wen_q <= res_we;
      end
      if (commit) begin
        hi_q <= hin_q;
        lo_q <= lon_q;
      end else if (mt_ok && md_op == MD_MTHI) begin
        hi_q <= A;
      end else if (mt_ok && md_op == MD_MTLO) begin
        lo_q <= A;
      end
    end
  end

  assign busy   = (state_q == S_BUSY);
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign md_out = (md_op == MD_MFHI) ? hi_q : (md_op == MD_MFLO) ? lo_q : '0;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at default parameters.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  md_op = MD_NONE;
  logic        flush = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic        busy;
  logic [31:0] HI, LO, md_out;
  int          checks = 0;
  int          errors = 0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .flush(flush),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .md_out(md_out)
  );

  always #5 clk = ~clk;

  // The hazard unit must never present start while busy.
  always @(negedge clk) begin
    if (reset && busy && start) begin
      errors++;
      $display("FAIL start_while_busy busy=%0b start=%0b expected no overlap", busy, start);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    start = 1'b1; md_op = op; A = a; B = b;
    step();
    start = 1'b0; md_op = MD_NONE;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      step();
    end
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a);
    md_op = op; A = a;
    step();
    md_op = MD_NONE;
  endtask

  task automatic test_reset();
    reset = 1'b0; md_op = MD_MFHI;
    repeat (3) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", HI); end
    checks++; if (LO !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", LO); end
    checks++; if (md_out !== 32'h0) begin errors++; $display("FAIL reset_md_out got=%h exp=0", md_out); end
    reset = 1'b1; md_op = MD_NONE;
    step();
  endtask

  task automatic test_mult();
    int cyc;
    run_op(MD_MULT, 32'hFFFFFFFE, 32'd3, cyc);
    checks++; if (cyc != 5) begin errors++; $display("FAIL mult_busy_cycles got=%0d exp=5", cyc); end
    checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
    checks++; if (LO !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got=%h exp=fffffffa", LO); end
    md_op = MD_MFHI; #1;
    checks++; if (md_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL mfhi got=%h exp=ffffffff", md_out); end
    md_op = MD_MFLO; #1;
    checks++; if (md_out !== 32'hFFFFFFFA) begin errors++; $display("FAIL mflo got=%h exp=fffffffa", md_out); end
    md_op = MD_NONE;
    step();
  endtask

  task automatic test_div();
    int cyc;
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, cyc);
    checks++; if (cyc != 10) begin errors++; $display("FAIL div_busy_cycles got=%0d exp=10", cyc); end
    checks++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got=%h exp=fffffffd", LO); end
    checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got=%h exp=ffffffff", HI); end
    run_op(MD_DIVU, 32'hFFFFFFF9, 32'd2, cyc);
    checks++; if (cyc != 10) begin errors++; $display("FAIL divu_busy_cycles got=%0d exp=10", cyc); end
    checks++; if (LO !== 32'h7FFFFFFC) begin errors++; $display("FAIL divu_lo got=%h exp=7ffffffc", LO); end
    checks++; if (HI !== 32'h1) begin errors++; $display("FAIL divu_hi got=%h exp=1", HI); end
  endtask

  task automatic test_div_corners();
    int cyc;
    mt(MD_MTHI, 32'h11);
    checks++; if (HI !== 32'h11) begin errors++; $display("FAIL mthi got=%h exp=11", HI); end
    run_op(MD_DIV, 32'd5, 32'd0, cyc);
    checks++; if (cyc != 10) begin errors++; $display("FAIL div0_busy_cycles got=%0d exp=10", cyc); end
    checks++; if (HI !== 32'h11) begin errors++; $display("FAIL div0_hi got=%h exp=11", HI); end
    checks++; if (LO !== 32'h7FFFFFFC) begin errors++; $display("FAIL div0_lo got=%h exp=7ffffffc", LO); end
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
    checks++; if (LO !== 32'h80000000) begin errors++; $display("FAIL divovf_lo got=%h exp=80000000", LO); end
    checks++; if (HI !== 32'h0) begin errors++; $display("FAIL divovf_hi got=%h exp=0", HI); end
  endtask

  task automatic test_flush();
    int cyc;
    start = 1'b1; flush = 1'b1; md_op = MD_MULT; A = 32'd3; B = 32'd3;
    step();
    start = 1'b0; flush = 1'b0; md_op = MD_NONE;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy got=%0b exp=0", busy); end
    repeat (6) step();
    checks++; if (HI !== 32'h0 || LO !== 32'h80000000)
      begin errors++; $display("FAIL flush_start_hilo got=%h_%h exp=00000000_80000000", HI, LO); end
    // Flush arriving after acceptance must not abort the op.
    start = 1'b1; md_op = MD_MULTU; A = 32'd3; B = 32'd4;
    step();
    start = 1'b0; md_op = MD_NONE; flush = 1'b1;
    step();
    flush = 1'b0;
    cyc = 1;
    while (busy && cyc < 100) begin cyc++; step(); end
    checks++; if (cyc != 5) begin errors++; $display("FAIL flush_busy_cycles got=%0d exp=5", cyc); end
    checks++; if (LO !== 32'hC) begin errors++; $display("FAIL flush_busy_lo got=%h exp=c", LO); end
    checks++; if (HI !== 32'h0) begin errors++; $display("FAIL flush_busy_hi got=%h exp=0", HI); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; md_op = MD_MULTU; A = 32'd7; B = 32'd5;
    step();
    start = 1'b0; md_op = MD_NONE;
    step();
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got=%0b exp=1", busy); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%0b exp=0", busy); end
    checks++; if (HI !== 32'h0 || LO !== 32'h0)
      begin errors++; $display("FAIL rmid_hilo got=%h_%h exp=0_0", HI, LO); end
    repeat (8) step();
    checks++; if (LO !== 32'h0) begin errors++; $display("FAIL rmid_late_commit got=%h exp=0", LO); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_late_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_madd();
    int cyc;
    mt(MD_MTHI, 32'h0);
    mt(MD_MTLO, 32'hFFFFFFFF);
    checks++; if (LO !== 32'hFFFFFFFF) begin errors++; $display("FAIL mtlo got=%h exp=ffffffff", LO); end
    run_op(MD_MADDU, 32'd1, 32'd1, cyc);
`ifdef MDU_MADD_EN
    checks++; if (cyc != 5) begin errors++; $display("FAIL maddu_busy_cycles got=%0d exp=5", cyc); end
    checks++; if (HI !== 32'h1) begin errors++; $display("FAIL maddu_hi got=%h exp=1", HI); end
    checks++; if (LO !== 32'h0) begin errors++; $display("FAIL maddu_lo got=%h exp=0", LO); end
`else
    checks++; if (cyc != 0) begin errors++; $display("FAIL maddu_off_busy got=%0d exp=0", cyc); end
    checks++; if (HI !== 32'h0) begin errors++; $display("FAIL maddu_off_hi got=%h exp=0", HI); end
    checks++; if (LO !== 32'hFFFFFFFF) begin errors++; $display("FAIL maddu_off_lo got=%h exp=ffffffff", LO); end
`endif
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_corners();
    test_flush();
    test_reset_mid();
    test_madd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
